// File: rtl/spsram_pkg.sv
// Shared types and constants for the single-port frame-memory controller.
package spsram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Supported read-latency range of the response pipeline.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/spsram_core.sv
// Byte-masked single-port SRAM core: active-low chip select and write enable,
// registered read. Contents are intentionally never reset.
module spsram_core #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_sys,
    input  logic                  csn,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [MASK_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0] dout
);

    // Index width of the array itself; the controller never presents an
    // address at or beyond ADDR_DEPTH while csn is low.
    localparam int IDX_W = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
    logic [IDX_W-1:0]      idx;

    assign idx = addr[IDX_W-1:0];

    // Per-lane masked write and one-cycle registered read.
    always_ff @(posedge clk_sys) begin
        if (!csn && !wen) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (mask[i]) begin
                    mem[idx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
        if (!csn && wen) begin
            dout <= mem[idx];
        end
    end

endmodule

// File: rtl/spsram_ctrl.sv
// Frame-memory controller: valid/ready request port onto a single-port SRAM,
// fixed-latency read pipeline feeding a fall-through response FIFO under an
// outstanding-read credit limit, plus a whole-frame clear engine.
//
// state | meaning
// IDLE  | serve requests; CLR_START latches the fill value and starts a clear
// CLEAR | fill every address with the latched value, one per cycle; requests blocked
module spsram_ctrl
    import spsram_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_DEPTH = 1080 * 2400,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WEN,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DIN,
    input  logic [MASK_WIDTH-1:0] REQ_MASK,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DOUT,
    input  logic                  CLR_START,
    input  logic [DATA_WIDTH-1:0] CLR_VALUE,
    output logic                  BUSY
);

    localparam int FIFO_DEPTH = RD_LATENCY + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W      = $clog2(RD_LATENCY + 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OUT_W-1:0]      MAX_OUT   = OUT_W'(RD_LATENCY);

    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("spsram_ctrl: RD_LATENCY out of supported range");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_left_q;
    logic [DATA_WIDTH-1:0] clr_value_q;
    logic [OUT_W-1:0]      outstanding_q;

    logic                  req_fire, rd_fire, addr_ok, rsp_fire;
    logic                  core_csn, core_wen;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_din, core_dout;
    logic [MASK_WIDTH-1:0] core_mask;

    logic                  oor_q;
    logic [DATA_WIDTH-1:0] stage0;
    logic [RD_LATENCY-1:0] vld_q;
    logic                  tail_valid;
    logic [DATA_WIDTH-1:0] tail_data;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  fifo_empty, push, pop;

    assign req_fire = REQ_VALID && REQ_READY;
    assign rd_fire  = req_fire && REQ_WEN;
    assign addr_ok  = 32'(REQ_ADDR) < 32'(ADDR_DEPTH);

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and FSM-driven outputs; the clear ends when the remaining count hits zero.
    always_comb begin
        state_d   = state_q;
        BUSY      = 1'b0;
        REQ_READY = 1'b0;
        case (state_q)
            IDLE: begin
                REQ_READY = (outstanding_q <= MAX_OUT);
                if (CLR_START) state_d = CLEAR;
            end
            CLEAR: begin
                BUSY = 1'b1;
                if (clr_left_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear engine: down-counter of remaining fill writes and the latched fill value.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            clr_left_q  <= LAST_ADDR;
            clr_value_q <= '0;
        end else if (state_q == IDLE) begin
            clr_left_q <= LAST_ADDR;
            if (CLR_START) clr_value_q <= CLR_VALUE;
        end else begin
            clr_left_q <= clr_left_q - 1'b1;
        end
    end

    // Core port mux: fill writes during a clear, otherwise accepted in-range requests.
    always_comb begin
        core_csn  = 1'b1;
        core_wen  = 1'b1;
        core_addr = REQ_ADDR;
        core_din  = REQ_DIN;
        core_mask = REQ_MASK;
        if (state_q == CLEAR) begin
            core_csn  = 1'b0;
            core_wen  = 1'b0;
            core_addr = LAST_ADDR - clr_left_q;
            core_din  = clr_value_q;
            core_mask = '1;
        end else if (req_fire && addr_ok) begin
            core_csn = 1'b0;
            core_wen = REQ_WEN;
        end
    end

    spsram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_DEPTH (ADDR_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_core (
        .clk_sys (CLK),
        .csn     (core_csn),
        .wen     (core_wen),
        .addr    (core_addr),
        .din     (core_din),
        .mask    (core_mask),
        .dout    (core_dout)
    );

    // Read-valid shift register and out-of-range marker for the core output stage.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_q <= '0;
            oor_q <= 1'b0;
        end else begin
            vld_q[0] <= rd_fire;
            for (int k = 1; k < RD_LATENCY; k++) vld_q[k] <= vld_q[k-1];
            oor_q <= rd_fire && !addr_ok;
        end
    end

    // Out-of-range reads leave the core idle, so their stale output is forced to zero.
    assign stage0     = oor_q ? '0 : core_dout;
    assign tail_valid = vld_q[RD_LATENCY-1];

    if (RD_LATENCY == 1) begin : g_no_pipe
        assign tail_data = stage0;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] pipe_q [RD_LATENCY-1];

        // Extra data stages beyond the core's own output register.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                for (int k = 0; k < RD_LATENCY - 1; k++) pipe_q[k] <= '0;
            end else begin
                pipe_q[0] <= stage0;
                for (int k = 1; k < RD_LATENCY - 1; k++) pipe_q[k] <= pipe_q[k-1];
            end
        end

        assign tail_data = pipe_q[RD_LATENCY-2];
    end

    // Pipeline tail bypasses the FIFO when it is empty and the consumer is ready.
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && RSP_READY;
    assign push       = tail_valid && !(fifo_empty && RSP_READY);
    assign RSP_VALID  = !fifo_empty || tail_valid;
    assign rsp_fire   = RSP_VALID && RSP_READY;

    // Response data: FIFO head first, then the pipeline tail, zero when idle.
    always_comb begin
        RSP_DOUT = '0;
        if (!fifo_empty)     RSP_DOUT = fifo_mem[rd_ptr_q];
        else if (tail_valid) RSP_DOUT = tail_data;
    end

    // FIFO storage; the credit limit guarantees a push never lands on a full FIFO.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr_q] <= tail_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Outstanding reads: from request acceptance until the response handshake.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            outstanding_q <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: tb/tb_spsram_ctrl.sv
// Directed bench for spsram_ctrl: 16 x 24-bit frame, read latency 2, 5-bit
// address so that address 16 is representable as an out-of-range access.
module tb_spsram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [4:0]  req_addr;
    logic [23:0] req_din;
    logic [2:0]  req_mask;
    logic        rsp_valid, rsp_ready;
    logic [23:0] rsp_dout;
    logic        clr_start;
    logic [23:0] clr_value;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int busy_cnt;
    logic [23:0] model [16];

    always #5 clk = ~clk;

    spsram_ctrl #(
        .DATA_WIDTH (24),
        .ADDR_DEPTH (16),
        .ADDR_WIDTH (5),
        .RD_LATENCY (2)
    ) dut (
        .CLK       (clk),
        .RSTN      (rst_n),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_WEN   (req_wen),
        .REQ_ADDR  (req_addr),
        .REQ_DIN   (req_din),
        .REQ_MASK  (req_mask),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_DOUT  (rsp_dout),
        .CLR_START (clr_start),
        .CLR_VALUE (clr_value),
        .BUSY      (busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted write; the reference model applies the byte mask, ignores out-of-range.
    task automatic wr(input logic [4:0] a, input logic [23:0] d, input logic [2:0] m);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = a;
        req_din   = d;
        req_mask  = m;
        if (a < 5'd16) begin
            for (int l = 0; l < 3; l++) begin
                if (m[l]) model[a[3:0]][8*l +: 8] = d[8*l +: 8];
            end
        end
        cyc();
        req_valid = 1'b0;
    endtask

    // Single read: nothing one cycle after acceptance, data two cycles after.
    task automatic rd_chk(input logic [4:0] a, input logic [23:0] exp, input string tag);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = a;
        cyc();
        req_valid = 1'b0;
        chk1({tag, "_early_valid"}, rsp_valid, 1'b0);
        chk24({tag, "_early_dout"}, rsp_dout, 24'h0);
        cyc();
        chk1({tag, "_valid"}, rsp_valid, 1'b1);
        chk24({tag, "_data"}, rsp_dout, exp);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_din   = '0;
        req_mask  = '0;
        rsp_ready = 1'b1;
        clr_start = 1'b0;
        clr_value = '0;
        #1 rst_n = 1'b0;
        repeat (3) cyc();

        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk24("rst_rsp_dout", rsp_dout, 24'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 16; i++) wr(5'(i), 24'hA00000 + 24'(i), 3'b111);

        // Masked write then read-back.
        wr(5'd5, 24'hABCDEF, 3'b111);
        wr(5'd5, 24'h001200, 3'b010);
        rd_chk(5'd5, 24'hAB12EF, "masked");
        cyc();

        // Streaming: eight back-to-back reads, responses two cycles behind.
        rsp_ready = 1'b1;
        req_wen   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                req_valid = 1'b1;
                req_addr  = 5'(i);
                chk1($sformatf("stream_ready_%0d", i), req_ready, 1'b1);
            end else begin
                req_valid = 1'b0;
            end
            if (i >= 2) begin
                chk1($sformatf("stream_valid_%0d", i - 2), rsp_valid, 1'b1);
                chk24($sformatf("stream_data_%0d", i - 2), rsp_dout, model[i-2]);
            end else begin
                chk1($sformatf("stream_idle_%0d", i), rsp_valid, 1'b0);
            end
            cyc();
        end
        chk1("stream_done", rsp_valid, 1'b0);

        // Backpressure: three reads fill the credit, then REQ_READY drops.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 5'(10 + i);
            chk1($sformatf("bp_ready_%0d", i), req_ready, 1'b1);
            cyc();
        end
        req_addr = 5'd13;
        for (int i = 0; i < 3; i++) begin
            chk1($sformatf("bp_blocked_%0d", i), req_ready, 1'b0);
            chk1($sformatf("bp_hold_valid_%0d", i), rsp_valid, 1'b1);
            chk24($sformatf("bp_hold_data_%0d", i), rsp_dout, model[10]);
            cyc();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk1("bp_still_blocked", req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk1($sformatf("bp_drain_valid_%0d", i), rsp_valid, 1'b1);
            chk24($sformatf("bp_drain_data_%0d", i), rsp_dout, model[10+i]);
            cyc();
        end
        chk1("bp_drain_empty", rsp_valid, 1'b0);
        chk1("bp_ready_back", req_ready, 1'b1);

        // Clear with a write accepted in the same cycle.
        chk1("clr_pre_ready", req_ready, 1'b1);
        chk1("clr_pre_busy", busy, 1'b0);
        clr_start = 1'b1;
        clr_value = 24'h5A5A5A;
        wr(5'd3, 24'h111111, 3'b111);
        clr_start = 1'b0;
        busy_cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            chk1($sformatf("clr_busy_%0d", k), busy, k < 16);
            chk1($sformatf("clr_ready_%0d", k), req_ready, k >= 16);
            if (busy) busy_cnt++;
            clr_start = (k == 4);
            if (k == 4) clr_value = 24'h000000;
            cyc();
        end
        chk24("clr_busy_cycles", 24'(busy_cnt), 24'd16);
        for (int i = 0; i < 16; i++) model[i] = 24'h5A5A5A;
        for (int i = 0; i < 16; i++) rd_chk(5'(i), model[i], $sformatf("clr_rd_%0d", i));
        cyc();

        // Reset in the middle of a clear.
        for (int i = 0; i < 16; i++) wr(5'(i), 24'hB00000 + 24'(i), 3'b111);
        clr_start = 1'b1;
        clr_value = 24'hC3C3C3;
        cyc();
        clr_start = 1'b0;
        repeat (6) cyc();
        chk1("mid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_rsp_valid", rsp_valid, 1'b0);
        chk1("mid_req_ready", req_ready, 1'b1);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) model[i] = 24'hC3C3C3;
        for (int i = 0; i < 16; i++) rd_chk(5'(i), model[i], $sformatf("mid_rd_%0d", i));
        cyc();

        // Out-of-range write dropped, read returns zero.
        wr(5'd16, 24'h123456, 3'b111);
        rd_chk(5'd16, 24'h000000, "oor_rd");
        cyc();
        rd_chk(5'd0, model[0], "oor_addr0");
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
